// File: rtl/port_event_fifo.sv
// Byte FIFO between an external producer and the MCU port bus: pushes come from ext_valid,
// firmware reads head/status and pops via control writes. Define PEF_SYNC_EN to synchronize ext inputs.
module port_event_fifo #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] DATA_ID   = 8'h21,
    parameter logic [7:0] STATUS_ID = 8'h22,
    parameter logic [7:0] CTRL_ID   = 8'h41
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ext_data,
    input  logic       ext_valid,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] in_port,
    output logic       interrupt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ie_q, ie_d;
    logic          interrupt_q, interrupt_d;

    logic          push_req;
    logic [7:0]    push_data;

`ifdef PEF_SYNC_EN
    logic [7:0] sync1_data_q, sync1_data_d;
    logic [7:0] sync2_data_q, sync2_data_d;
    logic       sync1_valid_q, sync1_valid_d;
    logic       sync2_valid_q, sync2_valid_d;
    logic       valid_prev_q, valid_prev_d;

    // Two-flop synchronizer, then a rising-edge detect so a long pulse pushes only once.
    always_comb begin
        sync1_data_d  = ext_data;
        sync2_data_d  = sync1_data_q;
        sync1_valid_d = ext_valid;
        sync2_valid_d = sync1_valid_q;
        valid_prev_d  = sync2_valid_q;
        push_req      = sync2_valid_q & ~valid_prev_q;
        push_data     = sync2_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_data_q  <= '0;
            sync2_data_q  <= '0;
            sync1_valid_q <= 1'b0;
            sync2_valid_q <= 1'b0;
            valid_prev_q  <= 1'b0;
        end else begin
            sync1_data_q  <= sync1_data_d;
            sync2_data_q  <= sync2_data_d;
            sync1_valid_q <= sync1_valid_d;
            sync2_valid_q <= sync2_valid_d;
            valid_prev_q  <= valid_prev_d;
        end
    end
`else
    always_comb begin
        push_req  = ext_valid;
        push_data = ext_data;
    end
`endif

    logic ctrl_wr;
    logic pop_req;
    logic clr_req;
    logic flush_req;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic overflow;

    // A pop frees the slot a simultaneous push needs, so a full FIFO still accepts it; flush beats both.
    always_comb begin
        ctrl_wr   = io_strb && (port_id == CTRL_ID);
        pop_req   = ctrl_wr & out_port[0];
        clr_req   = ctrl_wr & out_port[1];
        flush_req = ctrl_wr & out_port[2];
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        do_pop    = pop_req & ~empty & ~flush_req;
        do_push   = push_req & ~flush_req & (~full | do_pop);
        overflow  = push_req & ~flush_req & full & ~do_pop;
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_req) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        ovf_d       = (ovf_q & ~clr_req) | overflow;
        ie_d        = ctrl_wr ? out_port[7] : ie_q;
        interrupt_d = ie_d & (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            ie_q        <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            ie_q        <= ie_d;
            interrupt_q <= interrupt_d;
        end
    end

    logic [7:0] count_ext;
    logic [7:0] status_byte;

    // Count field is the low nibble, so a 16-deep full FIFO reads 0 with the full bit set.
    always_comb begin
        count_ext   = {{(8 - CW){1'b0}}, count_q};
        status_byte = {full, empty, ovf_q, ie_q, count_ext[3:0]};
        if (port_id == DATA_ID) begin
            in_port = empty ? 8'h00 : mem_q[rd_ptr_q];
        end else if (port_id == STATUS_ID) begin
            in_port = status_byte;
        end else begin
            in_port = 8'h00;
        end
    end

    assign interrupt = interrupt_q;

endmodule

// File: doc/port_event_fifo.md
# port_event_fifo

Input-side peripheral on the MCU port bus: buffers bytes from an external producer in a small FIFO and lets firmware consume them through port reads (`IN`) and port writes (`OUT`). Sits beside the MCU in the top-level wrapper, on the MCU clock. It drives the wrapper's input mux for its own port IDs and the MCU `interrupt` line. It complements the output-register path, which carries traffic the other way.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `DATA_ID`, 8'h21: read port returning the FIFO head byte.
- `STATUS_ID`, 8'h22: read port returning status.
- `CTRL_ID`, 8'h41: write port for control and pop.

- `clk` in 1: MCU clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `ext_data` in 8: producer byte.
- `ext_valid` in 1: one-cycle push strobe; `ext_data` is captured when it is high.
- `port_id` in 8: MCU port address.
- `out_port` in 8: MCU write data.
- `io_strb` in 1: MCU write strobe.
- `in_port` out 8: read data to the MCU; combinational from `port_id` and registered state only.
- `interrupt` out 1: level request to the MCU.

## Operation
- Storage: `DEPTH`×8 array, read pointer, write pointer, and count. Count is $clog2(DEPTH)+1 bits wide (0..DEPTH). Pointers wrap modulo `DEPTH`.
- Registered flags: `ovf` (sticky overflow) and `ie` (interrupt enable).
- Status byte: bit7 = full, bit6 = empty, bit5 = `ovf`, bit4 = `ie`, bits3:0 = count, zero-extended. For `DEPTH`=16, count 16 reads as 4'h0 with full=1.
- Read mux:
  - `port_id`==`DATA_ID`: head entry, or 8'h00 when empty.
  - `port_id`==`STATUS_ID`: status byte.
  - Any other `port_id`: 8'h00.
- Reads have no side effects.
- Control write: `io_strb`=1 and `port_id`==`CTRL_ID` at a rising edge.
  - bit0 POP: drop the head entry.
  - bit1 CLR_OVF: clear `ovf`.
  - bit2 FLUSH: pointers and count go to 0.
  - bit7: loaded into `ie` on every control write.
  - Bits 6:3 are ignored.
- Firmware consume sequence: `IN` STATUS_ID, `IN` DATA_ID, then `OUT` CTRL_ID with bit0=1 (and bit7 = desired `ie`).
- Push: `ext_valid`=1 pushes `ext_data` when not full.
- Push while full with no simultaneous POP: byte dropped, `ovf` set to 1.
- Push and POP in the same cycle:
  - Both take effect and count is unchanged.
  - This holds when full: the push is accepted.
  - When empty, the POP is ignored and only the push takes effect.
- POP when empty: ignored; no pointer or count change.
- FLUSH with push in the same cycle: FLUSH wins, the push is discarded, `ovf` is unchanged. FLUSH also overrides POP.
- CLR_OVF and a new overflow in the same cycle: `ovf` ends at 1 (set wins).
- `interrupt` = `ie` & (count≠0). It is driven only from registers.

## Timing
- Reset values: count 0, pointers 0, `ovf` 0, `ie` 0, `interrupt` 0. `in_port` reads 8'h00 at DATA_ID and 8'h40 at STATUS_ID.
- Push latency: byte pushed at edge N is readable at DATA_ID and reflected in status and `interrupt` from just after edge N. Without `PEF_SYNC_EN`, this is 1 cycle from the `ext_valid` assertion.
- POP at edge N: the next entry is visible at DATA_ID just after edge N.
- Reset asserted mid-stream clears the FIFO with no partial push or pop. The first push is accepted at the first rising edge after deassertion.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `PEF_SYNC_EN` defined:
  - `ext_data` and `ext_valid` pass through a 2-flop synchronizer before the push logic.
  - A rising-edge detector on the synchronized `ext_valid` makes one push per asserted pulse of any length.
  - Push latency becomes 3 cycles.
  - Synchronizer flops reset to 0.
- `PEF_SYNC_EN` not defined: inputs are used directly as single-cycle synchronous strobes; latency 1 cycle.

## Test plan
- Reset, then read ports → STATUS_ID=8'h40, DATA_ID=8'h00, `interrupt`=0. Write CTRL 8'h80, push 8'hA5 → STATUS_ID=8'h11, DATA_ID=8'hA5, `interrupt`=1.
- Push 8'h01..8'h08 with `DEPTH`=8 → STATUS_ID=8'h88. Push 8'h09 → dropped, STATUS_ID=8'hA8. Eight POP writes return 8'h01..8'h08 in order, then STATUS_ID=8'h60.
- FIFO full, same-cycle push 8'h55 and POP → count stays 8, `ovf`=0, last entry is 8'h55. POP on empty → count 0, pointers unchanged.
- FLUSH coincident with push, and CLR_OVF coincident with overflow → count 0 with `ovf` unchanged in the first case; `ovf`=1 in the second.
- Assert `reset` with 3 entries and `ie`=1 → `interrupt` drops asynchronously, STATUS_ID=8'h40. Wrap-around: 20 push/pop pairs return data in order.
